// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//
// Hazard and forwarding controller that sits beside the decode stage. A
// scoreboard tracks the destination of every instruction in the DEPTH stages
// after decode (entry k = stage k: 1=EX, 2=ME, 3=WB, ...). From the scoreboard
// and the decode operands it produces:
//   - a registered forwarding select per EX operand,
//   - a fetch/decode hold when a needed result is not ready yet,
//   - a decode flush and an EX bubble for a taken branch or jump,
//   - saturating stall and flush event counters.
//
// Ports
//   Clk, Rst               clock, synchronous active-high reset
//   de_valid               decode holds a real instruction
//   de_rs1, de_rs2         decode source registers
//   de_use_rs1, de_use_rs2 source is actually read
//   de_rd                  decode destination register
//   de_ruwr                decode instruction writes the register file
//   de_dmrd                decode instruction is a load
//   ex_redirect            taken branch/jump in EX
//   fe_de_en               fetch/decode register enable (0 = hold)
//   flush_de               clear the decode instruction register
//   bubble_ex              clear the EX control register
//   fwd_a_sel, fwd_b_sel   EX operand source: 0 = register file, k = stage k
//   stall_cnt, flush_cnt   saturating event counters

module hazard_forward_ctrl #(
    parameter int DEPTH     = 3,
    parameter int AW        = 5,
    parameter int ALU_READY = 2,
    parameter int LD_READY  = 3,
    parameter int CNTW      = 32,
    parameter int SW        = $clog2(DEPTH + 1)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            de_valid,
    input  logic [AW-1:0]   de_rs1,
    input  logic [AW-1:0]   de_rs2,
    input  logic            de_use_rs1,
    input  logic            de_use_rs2,
    input  logic [AW-1:0]   de_rd,
    input  logic            de_ruwr,
    input  logic            de_dmrd,
    input  logic            ex_redirect,
    output logic            fe_de_en,
    output logic            flush_de,
    output logic            bubble_ex,
    output logic [SW-1:0]   fwd_a_sel,
    output logic [SW-1:0]   fwd_b_sel,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    // Scoreboard, bit/element k describes the instruction in stage k.
    logic [DEPTH:1] ent_v;
    logic [DEPTH:1] ent_wr;
    logic [DEPTH:1] ent_ld;
    logic [AW-1:0]  ent_rd [1:DEPTH];

    typedef struct packed {
        logic          hit;
        logic          ld;
        logic [SW-1:0] k;
    } lookup_t;

    // Youngest producer of rs: scanning from the oldest entry down lets the
    // smallest matching k overwrite any older match.
    function automatic lookup_t lookup(input logic [AW-1:0] rs, input logic use_rs);
        lookup_t r;
        r = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (use_rs && (rs != '0) && ent_v[k] && ent_wr[k] && (ent_rd[k] == rs)) begin
                r.hit = 1'b1;
                r.ld  = ent_ld[k];
                r.k   = SW'(k);
            end
        end
        return r;
    endfunction

    // The producer at k will be in stage k+1 once the consumer reaches EX.
    function automatic logic is_ready(input lookup_t lk);
        int need;
        need = lk.ld ? LD_READY : ALU_READY;
        return (int'(lk.k) + 1) >= need;
    endfunction

    // A producer in the last stage writes the register file this cycle and
    // the write-before-read file makes it visible to decode, so select 0.
    function automatic logic [SW-1:0] next_sel(input lookup_t lk);
        if (lk.hit && is_ready(lk) && (lk.k != SW'(DEPTH))) begin
            return lk.k + SW'(1);
        end
        return '0;
    endfunction

    lookup_t       lk_a;
    lookup_t       lk_b;
    logic          wait_a;
    logic          wait_b;
    logic          hazard;
    logic          stall;
    logic [SW-1:0] sel_a_d;
    logic [SW-1:0] sel_b_d;

    always_comb begin
        lk_a    = lookup(de_rs1, de_use_rs1);
        lk_b    = lookup(de_rs2, de_use_rs2);
        wait_a  = lk_a.hit && !is_ready(lk_a);
        wait_b  = lk_b.hit && !is_ready(lk_b);
        hazard  = de_valid && (wait_a || wait_b);
        // Redirect wins: the waiting decode instruction is wrong-path anyway.
        stall   = hazard && !ex_redirect;
        sel_a_d = next_sel(lk_a);
        sel_b_d = next_sel(lk_b);
    end

    assign flush_de  = ex_redirect;
    assign fe_de_en  = !stall;
    assign bubble_ex = stall || ex_redirect;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ent_v     <= '0;
            ent_wr    <= '0;
            ent_ld    <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                ent_rd[k] <= '0;
            end
            fwd_a_sel <= '0;
            fwd_b_sel <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            // Later stages always advance; only entry 1 depends on decode.
            ent_v  <= {ent_v[DEPTH-1:1],  de_valid && !bubble_ex};
            ent_wr <= {ent_wr[DEPTH-1:1], de_ruwr && (de_rd != '0)};
            ent_ld <= {ent_ld[DEPTH-1:1], de_dmrd};
            for (int k = DEPTH; k >= 2; k--) begin
                ent_rd[k] <= ent_rd[k-1];
            end
            ent_rd[1] <= de_rd;

            if (bubble_ex) begin
                fwd_a_sel <= '0;
                fwd_b_sel <= '0;
            end else begin
                fwd_a_sel <= sel_a_d;
                fwd_b_sel <= sel_b_d;
            end

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
            if (ex_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised hazard and forwarding controller for the segmented RISC-V core. It sits beside the decode stage and replaces the fixed two-source forwarding unit and single load-use detector. It tracks every in-flight destination register across a configurable number of post-decode stages and produces three things: a registered per-operand forwarding select for the execute stage, a fetch/decode hold, and a bubble/flush pair for branch redirects. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- DEPTH, 3, number of tracked stages after decode (1=EX, 2=ME, 3=WB, …); minimum 2.
- AW, 5, register address width.
- ALU_READY, 2, first stage whose ALU result is forwardable to EX.
- LD_READY, 3, first stage whose load data is forwardable to EX; must be ≥ ALU_READY and ≤ DEPTH.
- CNTW, 32, counter width.
- SW, derived, $clog2(DEPTH+1): forwarding select width.

Ports:
- Clk  in  1  clock; everything samples on the rising edge.
- Rst  in  1  reset, synchronous and active-high.
- de_valid  in  1  decode stage holds a real instruction.
- de_rs1, de_rs2  in  AW  decode source registers.
- de_use_rs1, de_use_rs2  in  1  source actually read.
- de_rd  in  AW  decode destination.
- de_ruwr  in  1  decode instruction writes the register file.
- de_dmrd  in  1  decode instruction is a load.
- ex_redirect  in  1  branch or jump taken in EX (NextPCSrc).
- fe_de_en  out  1  enable for PC_fe, PCInc_de, PC_de and Inst_de; 0 = hold.
- flush_de  out  1  clear Inst_de.
- bubble_ex  out  1  clear the EX control register (insert NOP).
- fwd_a_sel, fwd_b_sel  out  SW  EX operand source: 0 = register file value, k = result of stage k.
- stall_cnt, flush_cnt  out  CNTW  event counters.

## Operation
- Scoreboard holds DEPTH entries, each {v, rd, wr, ld}. Entry k describes the instruction currently in stage k.
- Every cycle the entries shift: entry[k+1] ← entry[k]. Entry[DEPTH] retires.
- Entry[1] ← {de_valid, de_rd, de_ruwr && de_rd≠0, de_dmrd} when the decode instruction advances. Otherwise entry[1] ← invalid (bubble).
- Match for a source rs: the smallest k with entry[k].v && entry[k].wr && entry[k].rd==rs && de_use && rs≠0. Only the youngest producer counts.
- Readiness: a producer found at k will sit in stage k+1 when the consumer reaches EX. It is ready if k+1 ≥ (ld ? LD_READY : ALU_READY).
- Forwarding select:
  - match found and ready → next fwd_*_sel = k+1.
  - no match, or k = DEPTH → next fwd_*_sel = 0.
  - The register file is write-before-read, so a WB producer is visible to decode.
- hazard = de_valid && any matched source not ready.
- Outputs:
  - flush_de = ex_redirect.
  - stall = hazard && !ex_redirect.
  - fe_de_en = !stall.
  - bubble_ex = stall || ex_redirect.
- While bubble_ex is 1, entry[1] ← invalid and fwd_*_sel ← 0.
- Counters:
  - stall_cnt increments on each cycle stall=1.
  - flush_cnt increments on each cycle ex_redirect=1.
  - Both saturate at all-ones and never wrap.
- Redirect has priority over stall. The stalled decode instruction is on the wrong path and is discarded.

## Timing
- Reset values: all entries invalid, fwd_a_sel = fwd_b_sel = 0, stall_cnt = flush_cnt = 0.
  - Consequence: after reset fe_de_en=1, flush_de=0, bubble_ex=0 (with ex_redirect=0).
- Rst asserted mid-stall clears the scoreboard on that edge. The hazard drops in the following cycle.
- Timing of each output:
  - fe_de_en, flush_de and bubble_ex are combinational from the scoreboard and the decode inputs, valid in the same cycle.
  - fwd_*_sel are registered and valid during the cycle the consumer occupies EX.
- Load-use with defaults: exactly one stall cycle, then fwd=3 (WB).
- Longer gaps: with LD_READY−ALU_READY>1, or producers further back, stalls repeat each cycle until ready. Every stall cycle is counted.
- Redirect latency: a single cycle. Decode is flushed and EX receives one bubble. Entries already in stage ≥2 are unaffected.
- de_valid=0 never stalls and inserts an invalid entry.

## Test plan
- Back-to-back ALU dependency: add x5 then sub x6,x5,x1 → no stall; fwd_a_sel=2 in the sub's EX cycle.
- Load-use: lw x7 then add x8,x7,x7 → one cycle with fe_de_en=0 and bubble_ex=1; then fwd_a_sel=fwd_b_sel=3; stall_cnt=1.
- x0 and unused operands: producer rd=x0, or de_use_rs2=0 with a matching rs2 → no stall, sel=0.
- Youngest producer wins: addi x9 twice in a row, then use x9 → fwd sel=2, not 3.
- Redirect during load-use: ex_redirect=1 in the same cycle as the hazard → fe_de_en=1, flush_de=1, bubble_ex=1; stall_cnt unchanged, flush_cnt=1.
- Parameter and boundary check:
  - DEPTH=4, LD_READY=4: a load-use produces 2 stall cycles, then sel=4.
  - CNTW=4: 20 stall cycles leave stall_cnt=15.
  - Rst mid-stall: all outputs return to reset values on the next cycle.
